// File: rtl/xike_status_cond_if.sv
// Status-conditioning bundle: raw event inputs toward the conditioner and the
// clean levels/counters it hands to the status register file.
interface xike_status_cond_if;
    logic        sync_raw;
    logic        mua_open_req;
    logic        mua_wren;
    logic        mua_eof_pulse;
    logic        status_rd;
    logic [4:0]  status_addr;
    logic        sync_in;
    logic        sync_rise;
    logic        mua_open;
    logic        mua_eof;
    logic [15:0] sync_count;
    logic [15:0] frame_count;
    logic [15:0] sync_stamp;

    modport slave (
        input  sync_raw, mua_open_req, mua_wren, mua_eof_pulse, status_rd, status_addr,
        output sync_in, sync_rise, mua_open, mua_eof, sync_count, frame_count, sync_stamp
    );

    modport master (
        output sync_raw, mua_open_req, mua_wren, mua_eof_pulse, status_rd, status_addr,
        input  sync_in, sync_rise, mua_open, mua_eof, sync_count, frame_count, sync_stamp
    );
endinterface

// File: rtl/xike_status_cond.sv
// Debounces the sync pin, tracks the MUA session (open level, sticky EOF, frame count).
// Optional XIKE_SYNC_TIMESTAMP_EN builds a frame_count capture on each accepted sync rise.
module xike_status_cond #(
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter logic [4:0]  EOF_ADDR     = 5'd3
) (
    input  logic              clk,
    input  logic              rst_n,
    xike_status_cond_if.slave bus
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DCNT_ONE = DW'(1);
    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYC);

    typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} deb_state_t;

    deb_state_t    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          s1_q, s1_d, s2_q, s2_d;
    logic          sync_rise_q, sync_rise_d;
    logic [15:0]   sync_count_q, sync_count_d;
    logic          mua_open_q, mua_open_d;
    logic          mua_eof_q, mua_eof_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          open_rise;
    logic          eof_clr_rd;
    logic          rise_accept;

    always_comb begin
        s1_d = bus.sync_raw;
        s2_d = s1_q;
    end

    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        rise_accept  = 1'b0;
        sync_rise_d  = 1'b0;
        sync_count_d = sync_count_q;
        case (state_q)
            LOW: begin
                if (s2_q) begin
                    state_d = CHK_HI;
                    dcnt_d  = DCNT_ONE;
                end
            end
            CHK_HI: begin
                if (!s2_q) begin
                    state_d = LOW;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_MAX) begin
                    state_d      = HIGH;
                    dcnt_d       = '0;
                    rise_accept  = 1'b1;
                    sync_rise_d  = 1'b1;
                    sync_count_d = sync_count_q + 16'd1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_ONE;
                end
            end
            HIGH: begin
                if (!s2_q) begin
                    state_d = CHK_LO;
                    dcnt_d  = DCNT_ONE;
                end
            end
            CHK_LO: begin
                if (s2_q) begin
                    state_d = HIGH;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_MAX) begin
                    state_d = LOW;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                dcnt_d  = '0;
            end
        endcase
    end

    // Session restart wins over a same-cycle write, which is never counted anyway
    // because the registered open level is still low on that cycle.
    always_comb begin
        open_rise     = bus.mua_open_req & ~mua_open_q;
        eof_clr_rd    = bus.status_rd && (bus.status_addr == EOF_ADDR);
        mua_open_d    = bus.mua_open_req;
        frame_count_d = frame_count_q;
        mua_eof_d     = mua_eof_q;
        if (open_rise) begin
            frame_count_d = 16'h0000;
        end else if (bus.mua_wren && mua_open_q && (frame_count_q != 16'hFFFF)) begin
            frame_count_d = frame_count_q + 16'd1;
        end
        if (bus.mua_eof_pulse && mua_open_q) begin
            mua_eof_d = 1'b1;
        end else if (open_rise || eof_clr_rd) begin
            mua_eof_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            state_q       <= LOW;
            dcnt_q        <= '0;
            sync_rise_q   <= 1'b0;
            sync_count_q  <= 16'h0000;
            mua_open_q    <= 1'b0;
            mua_eof_q     <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            sync_rise_q   <= sync_rise_d;
            sync_count_q  <= sync_count_d;
            mua_open_q    <= mua_open_d;
            mua_eof_q     <= mua_eof_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef XIKE_SYNC_TIMESTAMP_EN
    logic [15:0] sync_stamp_q, sync_stamp_d;

    // Captured on the accepting edge, so it sees the count before any same-cycle write.
    always_comb begin
        sync_stamp_d = rise_accept ? frame_count_q : sync_stamp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_stamp_q <= 16'h0000;
        end else begin
            sync_stamp_q <= sync_stamp_d;
        end
    end

    assign bus.sync_stamp = sync_stamp_q;
`else
    logic unused_rise_accept;
    assign unused_rise_accept = rise_accept;
    assign bus.sync_stamp     = 16'h0000;
`endif

    assign bus.sync_in     = (state_q == HIGH) || (state_q == CHK_LO);
    assign bus.sync_rise   = sync_rise_q;
    assign bus.mua_open    = mua_open_q;
    assign bus.mua_eof     = mua_eof_q;
    assign bus.sync_count  = sync_count_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_xike_status_cond.sv
// Scoreboard bench for xike_status_cond: expectations queued with stimulus, popped when
// the DUT output is sampled one step after the clock edge.
module tb_xike_status_cond;

    logic clk;
    logic rst_n;
    xike_status_cond_if bus_if();

    xike_status_cond #(
        .DEBOUNCE_CYC(16),
        .EOF_ADDR(5'd3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rise_pulses = 0;
    int hi_seen = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        if (bus_if.sync_rise === 1'b1) rise_pulses++;
        if (bus_if.sync_in === 1'b1) hi_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] stamp_exp;
`ifdef XIKE_SYNC_TIMESTAMP_EN
        stamp_exp = 16'd100;
`else
        stamp_exp = 16'd0;
`endif
        rst_n = 1'b0;
        bus_if.sync_raw      = 1'b0;
        bus_if.mua_open_req  = 1'b0;
        bus_if.mua_wren      = 1'b0;
        bus_if.mua_eof_pulse = 1'b0;
        bus_if.status_rd     = 1'b0;
        bus_if.status_addr   = 5'd0;
        repeat (3) tick();

        // Reset state
        sb_push("rst_sync_in", 0);     sb_check(32'(bus_if.sync_in));
        sb_push("rst_sync_rise", 0);   sb_check(32'(bus_if.sync_rise));
        sb_push("rst_mua_open", 0);    sb_check(32'(bus_if.mua_open));
        sb_push("rst_mua_eof", 0);     sb_check(32'(bus_if.mua_eof));
        sb_push("rst_sync_count", 0);  sb_check(32'(bus_if.sync_count));
        sb_push("rst_frame_count", 0); sb_check(32'(bus_if.frame_count));
        sb_push("rst_sync_stamp", 0);  sb_check(32'(bus_if.sync_stamp));
        rst_n = 1'b1;
        tick();

        // Sync held high: accepted exactly 18 edges after the first high sample
        rise_pulses = 0;
        bus_if.sync_raw = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 18) sb_push("rise_lat_e18", 0);
            if (i == 19) begin sb_push("rise_lat_e19", 1); sb_push("rise_pulse_e19", 1); end
            if (i == 20) sb_push("rise_pulse_e20", 0);
            tick();
            if (i == 18) sb_check(32'(bus_if.sync_in));
            if (i == 19) begin sb_check(32'(bus_if.sync_in)); sb_check(32'(bus_if.sync_rise)); end
            if (i == 20) sb_check(32'(bus_if.sync_rise));
        end
        sb_push("rise_pulse_cnt", 1); sb_check(32'(rise_pulses));
        sb_push("sync_count_1", 1);   sb_check(32'(bus_if.sync_count));

        // Falling edge has the same latency
        bus_if.sync_raw = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            if (i == 18) sb_push("fall_lat_e18", 1);
            if (i == 19) sb_push("fall_lat_e19", 0);
            tick();
            if (i >= 18) sb_check(32'(bus_if.sync_in));
        end
        repeat (6) tick();

        // 15-cycle glitch rejected
        hi_seen = 0;
        bus_if.sync_raw = 1'b1;
        repeat (15) tick();
        bus_if.sync_raw = 1'b0;
        repeat (25) tick();
        sb_push("glitch15_sync_in", 0); sb_check(32'(hi_seen));
        sb_push("glitch15_count", 1);   sb_check(32'(bus_if.sync_count));

        // Shortest pulse that survives the full debounce window
        bus_if.sync_raw = 1'b1;
        repeat (17) tick();
        bus_if.sync_raw = 1'b0;
        repeat (40) tick();
        sb_push("pulse_seen", 1);    sb_check(32'(hi_seen != 0));
        sb_push("pulse_count", 2);   sb_check(32'(bus_if.sync_count));
        sb_push("pulse_settled", 0); sb_check(32'(bus_if.sync_in));

        // Open session, 100 frames
        bus_if.mua_open_req = 1'b1;
        tick();
        sb_push("open_level", 1); sb_check(32'(bus_if.mua_open));
        sb_push("open_frame0", 0); sb_check(32'(bus_if.frame_count));
        bus_if.mua_wren = 1'b1;
        repeat (100) tick();
        bus_if.mua_wren = 1'b0;
        sb_push("frames_100", 100); sb_check(32'(bus_if.frame_count));

        // Sync rise captures the frame count (when the stamp is built)
        bus_if.sync_raw = 1'b1;
        repeat (19) tick();
        sb_push("stamp_rise", 1);        sb_check(32'(bus_if.sync_rise));
        sb_push("stamp_val", 32'(stamp_exp)); sb_check(32'(bus_if.sync_stamp));
        sb_push("stamp_count", 3);       sb_check(32'(bus_if.sync_count));
        bus_if.sync_raw = 1'b0;
        repeat (25) tick();

        // Saturation, hold after close, reset on reopen
        bus_if.mua_wren = 1'b1;
        repeat (65600) tick();
        bus_if.mua_wren = 1'b0;
        tick();
        sb_push("frame_sat", 32'hFFFF); sb_check(32'(bus_if.frame_count));
        bus_if.mua_open_req = 1'b0;
        repeat (2) tick();
        sb_push("close_level", 0);       sb_check(32'(bus_if.mua_open));
        sb_push("close_hold", 32'hFFFF); sb_check(32'(bus_if.frame_count));
        bus_if.mua_open_req = 1'b1;
        bus_if.mua_wren = 1'b1;
        tick();
        bus_if.mua_wren = 1'b0;
        sb_push("reopen_frame0", 0); sb_check(32'(bus_if.frame_count));
        bus_if.mua_wren = 1'b1;
        tick();
        bus_if.mua_wren = 1'b0;
        sb_push("reopen_count1", 1); sb_check(32'(bus_if.frame_count));

        // Sticky EOF
        bus_if.mua_eof_pulse = 1'b1;
        tick();
        bus_if.mua_eof_pulse = 1'b0;
        sb_push("eof_set", 1); sb_check(32'(bus_if.mua_eof));
        bus_if.status_rd = 1'b1;
        bus_if.status_addr = 5'd2;
        tick();
        bus_if.status_rd = 1'b0;
        sb_push("eof_rd_addr2", 1); sb_check(32'(bus_if.mua_eof));
        bus_if.status_rd = 1'b1;
        bus_if.status_addr = 5'd3;
        sb_push("eof_during_rd", 1); sb_check(32'(bus_if.mua_eof));
        tick();
        bus_if.status_rd = 1'b0;
        sb_push("eof_clr_addr3", 0); sb_check(32'(bus_if.mua_eof));
        bus_if.mua_eof_pulse = 1'b1;
        bus_if.status_rd = 1'b1;
        tick();
        bus_if.mua_eof_pulse = 1'b0;
        bus_if.status_rd = 1'b0;
        sb_push("eof_set_wins", 1); sb_check(32'(bus_if.mua_eof));
        bus_if.status_rd = 1'b1;
        tick();
        bus_if.status_rd = 1'b0;
        sb_push("eof_clr_again", 0); sb_check(32'(bus_if.mua_eof));
        bus_if.mua_open_req = 1'b0;
        repeat (2) tick();
        bus_if.mua_eof_pulse = 1'b1;
        tick();
        bus_if.mua_eof_pulse = 1'b0;
        sb_push("eof_closed_ignored", 0); sb_check(32'(bus_if.mua_eof));

        // Async reset mid-debounce and mid-session
        bus_if.mua_open_req = 1'b1;
        tick();
        bus_if.mua_wren = 1'b1;
        repeat (5) tick();
        bus_if.mua_wren = 1'b0;
        bus_if.mua_eof_pulse = 1'b1;
        tick();
        bus_if.mua_eof_pulse = 1'b0;
        sb_push("pre_rst_frame5", 5); sb_check(32'(bus_if.frame_count));
        sb_push("pre_rst_eof", 1);    sb_check(32'(bus_if.mua_eof));
        bus_if.sync_raw = 1'b1;
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        sb_push("arst_sync_in", 0);     sb_check(32'(bus_if.sync_in));
        sb_push("arst_mua_open", 0);    sb_check(32'(bus_if.mua_open));
        sb_push("arst_mua_eof", 0);     sb_check(32'(bus_if.mua_eof));
        sb_push("arst_sync_count", 0);  sb_check(32'(bus_if.sync_count));
        sb_push("arst_frame_count", 0); sb_check(32'(bus_if.frame_count));
        sb_push("arst_sync_stamp", 0);  sb_check(32'(bus_if.sync_stamp));
        bus_if.mua_open_req = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            if (i == 18) sb_push("post_rst_e18", 0);
            if (i == 19) sb_push("post_rst_e19", 1);
            tick();
            if (i >= 18) sb_check(32'(bus_if.sync_in));
        end
        sb_push("post_rst_count", 1); sb_check(32'(bus_if.sync_count));

        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
